uart_tx_fifo: RTL and testbench
===============================

UART_TX_FIFO -- requirements
Module: uart_tx_fifo

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 87, meaning clk cycles per UART bit (minimum 2).
REQ-002 SHALL have parameter FIFO_DEPTH, default 8, meaning byte capacity of the input FIFO (power of two, minimum 2).
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port wr_en, input, 1 bit: byte-valid strobe from the upstream I2C slave stage.
REQ-006 SHALL have port wr_data, input, 8 bits: byte to transmit, sampled when wr_en=1.
REQ-007 SHALL have port full, output, 1 bit: FIFO holds FIFO_DEPTH bytes.
REQ-008 SHALL have port empty, output, 1 bit: FIFO holds 0 bytes.
REQ-009 SHALL have port overflow, output, 1 bit: one-cycle pulse when a write is dropped.
REQ-010 SHALL have port tx_busy, output, 1 bit: FSM is not in IDLE.
REQ-011 SHALL have port tx, output, 1 bit: registered UART serial line, idle high.

Function
REQ-012 SHALL store bytes first-in first-out; count is 0..FIFO_DEPTH; read and write pointers wrap modulo FIFO_DEPTH.
REQ-013 SHALL accept a write when wr_en=1 and the FIFO is not full, or when it is full and a pop occurs in the same cycle.
REQ-014 SHALL drop a write when wr_en=1, full=1 and no pop occurs in that cycle; overflow=1 for exactly the following cycle; FIFO contents unchanged.
REQ-015 SHALL, on a simultaneous write and pop, leave count unchanged and store the new byte behind all existing bytes.
REQ-016 SHALL implement FSM states IDLE, START, DATA, PARITY (macro only, see REQ-026), STOP.
REQ-017 IDLE: when FIFO not empty at an edge, SHALL load the head byte into the shift register, pop it, clear the bit counter, drive tx=0 and go to START.
REQ-018 START, DATA, PARITY and STOP SHALL each hold tx for exactly CLKS_PER_BIT cycles, timed by a baud counter running 0..CLKS_PER_BIT-1 and cleared on every state or bit change.
REQ-019 DATA SHALL send 8 bits LSB first; bit index 0..7; leaves DATA after bit 7 has been held for its full bit time.
REQ-020 STOP SHALL drive tx=1; at the end of the stop bit, SHALL go directly to START (pop and load, no idle gap) if the FIFO is not empty, else to IDLE.
REQ-021 Latency: for a write into an empty FIFO while IDLE, tx SHALL fall 2 rising edges after the edge that samples wr_en (count updates on edge 1; pop and tx=0 on edge 2).
REQ-022 Frame length SHALL be 10*CLKS_PER_BIT cycles without the macro and 11*CLKS_PER_BIT with it.
REQ-023 A byte written during a frame SHALL NOT alter the frame in progress.

Reset
REQ-024 When reset=1 at a rising edge, SHALL set FSM=IDLE, tx=1, tx_busy=0, count=0, pointers=0, empty=1, full=0, overflow=0, baud and bit counters=0; an in-progress frame is abandoned and buffered bytes are discarded.
REQ-025 Reset SHALL take priority over wr_en in the same cycle; the write is ignored and overflow stays 0.

Configuration
REQ-026 Macro UART_TX_PARITY_EN: when defined, SHALL insert the PARITY state between DATA and STOP, transmitting even parity (XOR of the 8 data bits); when undefined, DATA SHALL go directly to STOP and the PARITY state and its logic SHALL be absent.

Verification
REQ-027 Single byte: reset, then wr_en with 0x67, CLKS_PER_BIT=87 -> tx falls 2 edges later; bit sequence 0,1,1,1,0,0,1,1,0,1, each bit 87 cycles; tx_busy=1 for 870 cycles.
REQ-028 Parity: macro defined, byte 0x67 -> parity bit 1 between bit 7 and stop; frame 957 cycles. Byte 0x03 -> parity bit 0.
REQ-029 Back-to-back: write 0x55, 0xAA in consecutive cycles -> two frames with no idle cycle between the stop bit of 0x55 and the start bit of 0xAA; empty=1 after the second pop.
REQ-030 Overflow: FIFO_DEPTH=8, first byte popped, then 9 writes 0x01..0x09 during its frame -> full=1 after the 8th; 9th dropped with one overflow pulse; 0x01..0x08 transmitted in order.
REQ-031 Full plus pop: FIFO full and a write coincident with the pop edge -> write accepted, full stays 1, overflow stays 0.
REQ-032 Mid-frame reset: reset=1 for 1 cycle during bit 3 of 0x67 with 2 bytes queued -> tx=1, empty=1, tx_busy=0 after that edge; no further frame until a new write.

Source files
------------

// File: rtl/uart_tx_fifo.sv
// Purpose : byte FIFO feeding an 8N1 UART transmitter (8E1 when UART_TX_PARITY_EN is defined).
// Latency : a byte written into an empty FIFO while idle drives the start bit 2 edges after the write edge.
// Backpr. : none upstream; a write into a full FIFO with no pop that cycle is dropped and flagged on overflow.
//
// Parameters:
//   CLKS_PER_BIT : clk cycles per UART bit (>= 2)
//   FIFO_DEPTH   : FIFO capacity in bytes (power of two, >= 2)
// Ports:
//   clk      : single clock, rising edge
//   reset    : synchronous active-high reset
//   wr_en    : byte-valid strobe from the upstream stage
//   wr_data  : byte to transmit, sampled when wr_en=1
//   full     : FIFO holds FIFO_DEPTH bytes
//   empty    : FIFO holds 0 bytes
//   overflow : one-cycle pulse the cycle after a write was dropped
//   tx_busy  : transmitter is not idle
//   tx       : registered serial line, idle high
// Macro:
//   UART_TX_PARITY_EN : when defined, an even-parity bit is sent between data bit 7 and the stop bit.

module uart_tx_fifo #(
  parameter int CLKS_PER_BIT = 87,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       wr_en,
  input  logic [7:0] wr_data,
  output logic       full,
  output logic       empty,
  output logic       overflow,
  output logic       tx_busy,
  output logic       tx
);

  localparam int AW = (FIFO_DEPTH > 2) ? $clog2(FIFO_DEPTH) : 1;
  localparam int BW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BW-1:0] BAUD_LAST  = BW'(CLKS_PER_BIT - 1);
  localparam logic [AW:0]   COUNT_FULL = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
    S_PARITY = 3'd3,
`endif
    S_STOP   = 3'd4
  } state_t;

  // FIFO storage
  logic [7:0]    r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [AW:0]   r_count;
  logic          r_overflow;

  // Transmitter state
  state_t        r_state;
  logic [BW-1:0] r_baud;
  logic [2:0]    r_bit_idx;
  logic [7:0]    r_shift;
  logic          r_tx;

  state_t        w_state_nxt;
  logic [BW-1:0] w_baud_nxt;
  logic [2:0]    w_bit_nxt;
  logic [7:0]    w_shift_nxt;
  logic          w_tx_nxt;
  logic          w_pop;
  logic          w_push;
  logic          w_bit_end;
  logic [7:0]    w_head;

  assign full      = (r_count == COUNT_FULL);
  assign empty     = (r_count == '0);
  assign overflow  = r_overflow;
  assign tx_busy   = (r_state != S_IDLE);
  assign tx        = r_tx;
  assign w_head    = r_mem[r_rptr];
  assign w_bit_end = (r_baud == BAUD_LAST);

  // A full FIFO can still take a byte when the transmitter pops in the same
  // cycle; the head is read before the write lands, so order is preserved.
  assign w_push = wr_en & ~reset & (~full | w_pop);

  // ---------------------------------------------------------------------
  // FIFO
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_overflow <= wr_en & full & ~w_pop;
      if (w_push) begin
        r_wptr <= r_wptr + AW'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + AW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // ---------------------------------------------------------------------
  // Transmitter FSM: state register
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_baud    <= '0;
      r_bit_idx <= '0;
      r_shift   <= '0;
      r_tx      <= 1'b1;
    end else begin
      r_state   <= w_state_nxt;
      r_baud    <= w_baud_nxt;
      r_bit_idx <= w_bit_nxt;
      r_shift   <= w_shift_nxt;
      r_tx      <= w_tx_nxt;
    end
  end

  // ---------------------------------------------------------------------
  // Transmitter FSM: next state and outputs
  // r_shift keeps the whole byte for the frame; bits are picked by index so
  // the parity bit can be formed from it at the end of the data phase.
  // ---------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    w_baud_nxt  = r_baud;
    w_bit_nxt   = r_bit_idx;
    w_shift_nxt = r_shift;
    w_tx_nxt    = r_tx;
    w_pop       = 1'b0;

    case (r_state)
      S_IDLE: begin
        w_tx_nxt = 1'b1;
        if (!empty) begin
          w_pop       = 1'b1;
          w_shift_nxt = w_head;
          w_bit_nxt   = '0;
          w_baud_nxt  = '0;
          w_tx_nxt    = 1'b0;
          w_state_nxt = S_START;
        end
      end

      S_START: begin
        if (w_bit_end) begin
          w_baud_nxt  = '0;
          w_bit_nxt   = '0;
          w_tx_nxt    = r_shift[0];
          w_state_nxt = S_DATA;
        end else begin
          w_baud_nxt = r_baud + BW'(1);
        end
      end

      S_DATA: begin
        if (w_bit_end) begin
          w_baud_nxt = '0;
          if (r_bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            w_tx_nxt    = ^r_shift;
            w_state_nxt = S_PARITY;
`else
            w_tx_nxt    = 1'b1;
            w_state_nxt = S_STOP;
`endif
          end else begin
            w_bit_nxt = r_bit_idx + 3'd1;
            w_tx_nxt  = r_shift[r_bit_idx + 3'd1];
          end
        end else begin
          w_baud_nxt = r_baud + BW'(1);
        end
      end

`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        if (w_bit_end) begin
          w_baud_nxt  = '0;
          w_tx_nxt    = 1'b1;
          w_state_nxt = S_STOP;
        end else begin
          w_baud_nxt = r_baud + BW'(1);
        end
      end
`endif

      S_STOP: begin
        if (w_bit_end) begin
          w_baud_nxt = '0;
          if (!empty) begin
            // Chain straight into the next frame with no idle gap.
            w_pop       = 1'b1;
            w_shift_nxt = w_head;
            w_bit_nxt   = '0;
            w_tx_nxt    = 1'b0;
            w_state_nxt = S_START;
          end else begin
            w_tx_nxt    = 1'b1;
            w_state_nxt = S_IDLE;
          end
        end else begin
          w_baud_nxt = r_baud + BW'(1);
        end
      end

      default: begin
        w_tx_nxt    = 1'b1;
        w_baud_nxt  = '0;
        w_state_nxt = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Purpose : self-checking bench for uart_tx_fifo (frame-level reference model plus directed checks).
// Latency : n/a
// Backpr. : n/a
`timescale 1ns/1ps

module tb_uart_tx_fifo;

  localparam int CPB   = 87;
  localparam int DEPTH = 8;
`ifdef UART_TX_PARITY_EN
  localparam int NBITS     = 11;
  localparam int FRAME_LIT = 957;
`else
  localparam int NBITS     = 10;
  localparam int FRAME_LIT = 870;
`endif
  localparam int FRAME = NBITS * CPB;

  logic       clk;
  logic       reset;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       full;
  logic       empty;
  logic       overflow;
  logic       tx_busy;
  logic       tx;

  uart_tx_fifo #(
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (DEPTH)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .wr_en    (wr_en),
    .wr_data  (wr_data),
    .full     (full),
    .empty    (empty),
    .overflow (overflow),
    .tx_busy  (tx_busy),
    .tx       (tx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int fail_prints = 0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      if (fail_prints < 40) begin
        fail_prints++;
        $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
    end
  endtask

  // Serial bit k of the frame carrying byte b.
  function automatic logic frame_bit(input logic [7:0] b, input int k);
    if (k == 0) return 1'b0;
    if (k <= 8) return b[k-1];
`ifdef UART_TX_PARITY_EN
    if (k == 9) return ^b;
`endif
    return 1'b1;
  endfunction

  // ---------------------------------------------------------------------
  // Reference model: a byte queue and a frame timer counting cycles since
  // the current frame started; tx is looked up from the frame bit table.
  // ---------------------------------------------------------------------
  logic [7:0] mq [$];
  bit         m_valid = 1'b0;
  bit         m_busy;
  int         m_t;
  logic [7:0] m_cur;
  bit         m_ovf;
  bit         m_pop;

  always @(posedge clk) begin
    if (reset) begin
      mq.delete();
      m_busy  = 1'b0;
      m_t     = 0;
      m_ovf   = 1'b0;
      m_valid = 1'b1;
    end else if (m_valid) begin
      m_pop = 1'b0;
      if (!m_busy) begin
        if (mq.size() > 0) m_pop = 1'b1;
      end else if (m_t == FRAME - 1) begin
        if (mq.size() > 0) m_pop = 1'b1;
        else m_busy = 1'b0;
      end else begin
        m_t++;
      end
      m_ovf = wr_en && (mq.size() == DEPTH) && !m_pop;
      if (m_pop) begin
        m_cur  = mq.pop_front();
        m_busy = 1'b1;
        m_t    = 0;
      end
      if (wr_en && !m_ovf) mq.push_back(wr_data);
    end
    #1;
    if (m_valid) begin
      chk("cyc_tx",       int'(tx),       int'(m_busy ? frame_bit(m_cur, m_t / CPB) : 1'b1));
      chk("cyc_tx_busy",  int'(tx_busy),  int'(m_busy));
      chk("cyc_full",     int'(full),     int'(mq.size() == DEPTH));
      chk("cyc_empty",    int'(empty),    int'(mq.size() == 0));
      chk("cyc_overflow", int'(overflow), int'(m_ovf));
    end
  end

  // ---------------------------------------------------------------------
  // Simple UART receiver: mid-bit sampling, collects decoded bytes.
  // ---------------------------------------------------------------------
  logic [7:0] rx_q [$];
  bit         rx_en = 1'b1;

  initial begin : rx_proc
    logic [7:0] b;
    forever begin
      @(negedge clk);
      if (rx_en && tx === 1'b0) begin
        repeat (CPB / 2) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
          repeat (CPB) @(negedge clk);
          b[i] = tx;
        end
`ifdef UART_TX_PARITY_EN
        repeat (CPB) @(negedge clk);
`endif
        repeat (CPB) @(negedge clk);
        rx_q.push_back(b);
      end
    end
  end

  // ---------------------------------------------------------------------
  // Capture buffers, indexed by negedges from the start of capture.
  // ---------------------------------------------------------------------
  logic tx_log    [0:2199];
  logic busy_log  [0:2199];
  logic empty_log [0:2199];

  task automatic capture(input int n);
    for (int i = 0; i < n; i++) begin
      tx_log[i]    = tx;
      busy_log[i]  = tx_busy;
      empty_log[i] = empty;
      @(negedge clk);
    end
  endtask

  // Start bit, 0x67 LSB first, then (parity 1 or stop) and stop.
  int exp67 [11] = '{0, 1, 1, 1, 0, 0, 1, 1, 0, 1, 1};
  logic [7:0] exp_ovf [10] = '{8'hEE, 8'h01, 8'h02, 8'h03, 8'h04,
                               8'h05, 8'h06, 8'h07, 8'h08, 8'h99};

  initial begin : main
    int n;
    reset   = 1'b1;
    wr_en   = 1'b0;
    wr_data = 8'h00;
    repeat (2) @(negedge clk);

    // Reset state
    chk("rst_tx",       int'(tx),       1);
    chk("rst_busy",     int'(tx_busy),  0);
    chk("rst_empty",    int'(empty),    1);
    chk("rst_full",     int'(full),     0);
    chk("rst_overflow", int'(overflow), 0);
    reset = 1'b0;
    @(negedge clk);

    // Single byte 0x67: latency, bit sequence, frame length
    wr_en = 1'b1; wr_data = 8'h67;
    @(negedge clk);
    wr_en = 1'b0;
    chk("lat_e1_tx",    int'(tx),    1);
    chk("lat_e1_empty", int'(empty), 0);
    @(negedge clk);
    chk("lat_e2_tx",    int'(tx),      0);
    chk("lat_e2_busy",  int'(tx_busy), 1);
    chk("lat_e2_empty", int'(empty),   1);
    capture(FRAME + CPB);
    for (int k = 0; k < NBITS; k++) begin
      n = 0;
      for (int c = 0; c < CPB; c++) if (int'(tx_log[k*CPB + c]) == exp67[k]) n++;
      chk($sformatf("b67_bit%0d_cycles", k), n, CPB);
    end
    n = 0;
    for (int i = 0; i < FRAME + CPB; i++) if (busy_log[i]) n++;
    chk("b67_busy_len", n, FRAME_LIT);
    chk("b67_rx_count", rx_q.size(), 1);
    if (rx_q.size() > 0) chk("b67_rx_byte", int'(rx_q[0]), 'h67);
    rx_q.delete();

`ifdef UART_TX_PARITY_EN
    // Byte 0x03: even parity bit is 0
    wr_en = 1'b1; wr_data = 8'h03;
    @(negedge clk);
    wr_en = 1'b0;
    @(negedge clk);
    capture(FRAME + CPB);
    n = 0;
    for (int c = 0; c < CPB; c++) if (tx_log[9*CPB + c] == 1'b0) n++;
    chk("b03_parity_cycles", n, CPB);
    n = 0;
    for (int i = 0; i < FRAME + CPB; i++) if (busy_log[i]) n++;
    chk("b03_busy_len", n, FRAME_LIT);
    rx_q.delete();
`endif

    // Back-to-back 0x55, 0xAA
    wr_en = 1'b1; wr_data = 8'h55;
    @(negedge clk);
    wr_data = 8'hAA;
    @(negedge clk);
    wr_en = 1'b0;
    capture(2*FRAME + CPB);
    chk("b2b_stop_last_tx",   int'(tx_log[FRAME-1]),    1);
    chk("b2b_start2_tx",      int'(tx_log[FRAME]),      0);
    chk("b2b_empty_before",   int'(empty_log[FRAME-1]), 0);
    chk("b2b_empty_after",    int'(empty_log[FRAME]),   1);
    n = 0;
    for (int i = 0; i < 2*FRAME; i++) if (busy_log[i]) n++;
    chk("b2b_busy_no_gap",    n, 2*FRAME_LIT);
    chk("b2b_busy_end",       int'(busy_log[2*FRAME]), 0);
    chk("b2b_rx_count",       rx_q.size(), 2);
    if (rx_q.size() == 2) begin
      chk("b2b_rx0", int'(rx_q[0]), 'h55);
      chk("b2b_rx1", int'(rx_q[1]), 'hAA);
    end
    rx_q.delete();

    // Overflow: 0xEE popped, then 0x01..0x09 written during its frame
    wr_en = 1'b1; wr_data = 8'hEE;
    @(negedge clk);
    for (int v = 1; v <= 9; v++) begin
      wr_data = 8'(v);
      @(negedge clk);
      if (v == 7) chk("ovf_full_after7", int'(full), 0);
      if (v == 8) begin
        chk("ovf_full_after8", int'(full),     1);
        chk("ovf_none_after8", int'(overflow), 0);
      end
      if (v == 9) begin
        chk("ovf_pulse",      int'(overflow), 1);
        chk("ovf_full_still", int'(full),     1);
      end
    end
    wr_en = 1'b0;
    @(negedge clk);
    chk("ovf_pulse_end", int'(overflow), 0);

    // Full plus pop: write lands on the edge that ends the 0xEE frame
    repeat (FRAME - 10) @(negedge clk);
    wr_en = 1'b1; wr_data = 8'h99;
    @(negedge clk);
    wr_en = 1'b0;
    chk("fpop_full",     int'(full),     1);
    chk("fpop_overflow", int'(overflow), 0);
    @(negedge clk);
    chk("fpop_overflow_next", int'(overflow), 0);

    repeat (9*FRAME + 2*CPB) @(negedge clk);
    chk("ovf_rx_count", rx_q.size(), 10);
    if (rx_q.size() == 10) begin
      for (int i = 0; i < 10; i++) chk($sformatf("ovf_rx%0d", i), int'(rx_q[i]), int'(exp_ovf[i]));
    end
    chk("drain_empty", int'(empty),   1);
    chk("drain_busy",  int'(tx_busy), 0);
    rx_q.delete();

    // Mid-frame reset during bit 3 of 0x67 with two bytes queued
    wr_en = 1'b1; wr_data = 8'h67;
    @(negedge clk);
    wr_data = 8'h11;
    @(negedge clk);
    wr_data = 8'h22;
    @(negedge clk);
    wr_en = 1'b0;
    repeat (4*CPB + 10 - 1) @(negedge clk);
    chk("mrst_pre_tx",    int'(tx),    0);
    chk("mrst_pre_empty", int'(empty), 0);
    rx_en = 1'b0;
    reset = 1'b1; wr_en = 1'b1; wr_data = 8'h5A;
    @(negedge clk);
    reset = 1'b0; wr_en = 1'b0;
    chk("mrst_tx",       int'(tx),       1);
    chk("mrst_empty",    int'(empty),    1);
    chk("mrst_busy",     int'(tx_busy),  0);
    chk("mrst_full",     int'(full),     0);
    chk("mrst_overflow", int'(overflow), 0);
    @(negedge clk);
    chk("mrst_overflow_next", int'(overflow), 0);
    capture(2*FRAME);
    n = 0;
    for (int i = 0; i < 2*FRAME; i++) if (busy_log[i] || !tx_log[i]) n++;
    chk("mrst_no_frame", n, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
